// File: rtl/e_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// e_mdu_ctrl -- multi-cycle multiply/divide sequencer for the Execute stage.
// Owns the architectural HI/LO pair and emulates the latency of a real
// iterative multiplier/divider with a down-counter. The result is computed
// at acceptance, parked in a temp pair, and committed when the counter
// expires.
//
// Ports:
//   clk    in   1  pipeline clock, rising edge
//   reset  in   1  asynchronous active-low reset
//   start  in   1  E-stage instruction is an md-class op
//   op     in   3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   A      in  32  rs operand
//   B      in  32  rt operand
//   req    in   1  exception/interrupt flush; blocks acceptance this cycle
//   busy   out  1  high while a mult/div is in flight (registered)
//   HI     out 32  architectural HI
//   LO     out 32  architectural LO
// ---------------------------------------------------------------------------
module e_mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            skip_q;     // divide-by-zero: suppress commit
  logic [31:0]     hi_q, lo_q;
  logic [31:0]     tmp_hi_q, tmp_lo_q;

  md_op_t          op_e;
  logic            accept;
  logic [63:0]     a_ext, b_ext, prod;
  logic            sdiv, a_neg, b_neg;
  logic [31:0]     a_mag, b_mag, q_mag, r_mag, quo, rem;

  assign op_e   = md_op_t'(op);
  assign accept = start & ~req & (state_q == IDLE) &
                  (op_e != OP_NONE) & (op_e != OP_RSVD);

  // Product and quotient/remainder computed up front; the counter only
  // models the latency. Signed division is done on magnitudes so that
  // 0x80000000 / -1 wraps to 0x80000000 with remainder 0 deterministically.
  always_comb begin
    a_ext = (op_e == OP_MULT) ? {{32{A[31]}}, A} : {32'b0, A};
    b_ext = (op_e == OP_MULT) ? {{32{B[31]}}, B} : {32'b0, B};
    prod  = a_ext * b_ext;

    sdiv  = (op_e == OP_DIV);
    a_neg = sdiv & A[31];
    b_neg = sdiv & B[31];
    a_mag = a_neg ? -A : A;
    b_mag = (B == '0) ? 32'd1 : (b_neg ? -B : B);
    q_mag = a_mag / b_mag;
    r_mag = a_mag % b_mag;
    quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      skip_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (op_e)
              OP_MTHI: hi_q <= A;
              OP_MTLO: lo_q <= A;
              OP_MULT, OP_MULTU: begin
                tmp_hi_q <= prod[63:32];
                tmp_lo_q <= prod[31:0];
                skip_q   <= 1'b0;
                cnt_q    <= CW'(MULT_CYCLES);
                state_q  <= RUN;
                busy_q   <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                tmp_hi_q <= rem;
                tmp_lo_q <= quo;
                skip_q   <= (B == '0);
                cnt_q    <= CW'(DIV_CYCLES);
                state_q  <= RUN;
                busy_q   <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt_q == CW'(1)) begin
            if (!skip_q) begin
              hi_q <= tmp_hi_q;
              lo_q <= tmp_lo_q;
            end
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_e_mdu_ctrl -- self-checking bench for e_mdu_ctrl.
// Table of {op, operands, expected HI/LO, expected busy cycles} applied in a
// loop through a scoreboard queue, followed by hand-written sequences for
// flush-blocked start, start during RUN, req during RUN and async reset
// mid-divide.
// ---------------------------------------------------------------------------
module tb_e_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, req;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .req   (req),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned cyc;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned cyc;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one request for a single cycle; returns at the negedge after the
  // accepting edge (first busy cycle for mult/div).
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic r);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b; req = r;
    @(negedge clk);
    start = 1'b0; op = 3'd0; req = 1'b0;
  endtask

  // Count remaining busy cycles (checking HI/LO hold), then pop and compare.
  task automatic drain(input string name, input logic [31:0] old_hi, input logic [31:0] old_lo,
                       input int unsigned c0);
    int unsigned c;
    exp_t e;
    c = c0;
    while (busy === 1'b1 && c < 200) begin
      chk({name, " hold HI"}, HI, old_hi);
      chk({name, " hold LO"}, LO, old_lo);
      c++;
      @(negedge clk);
    end
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", name);
      return;
    end
    e = sb.pop_front();
    chk({name, " busy cycles"}, c, e.cyc);
    chk({name, " HI"}, HI, e.hi);
    chk({name, " LO"}, LO, e.lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] oh, ol;

    vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5,  "mult_neg"};
    vecs[1]  = '{3'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5,  "multu"};
    vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_neg"};
    vecs[3]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10, "divu"};
    vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, "div_ovf"};
    vecs[5]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10, "div_negb"};
    vecs[6]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5,  "mult_min"};
    vecs[7]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5,  "multu_max"};
    vecs[8]  = '{3'd5, 32'h00001234, 32'd0,        32'h00001234, 32'h00000001, 0,  "mthi"};
    vecs[9]  = '{3'd6, 32'h00005678, 32'd0,        32'h00001234, 32'h00005678, 0,  "mtlo"};
    vecs[10] = '{3'd4, 32'd7,        32'd0,        32'h00001234, 32'h00005678, 10, "divu_by0"};
    vecs[11] = '{3'd0, 32'hFFFFFFFF, 32'd1,        32'h00001234, 32'h00005678, 0,  "op_none"};
    vecs[12] = '{3'd7, 32'hFFFFFFFF, 32'd1,        32'h00001234, 32'h00005678, 0,  "op_rsvd"};
    vecs[13] = '{3'd3, 32'h80000000, 32'd0,        32'h00001234, 32'h00005678, 10, "div_by0"};

    reset = 1'b0; start = 1'b0; req = 1'b0; op = 3'd0; A = '0; B = '0;
    #12;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      oh = HI; ol = LO;
      sb.push_back('{vecs[i].hi, vecs[i].lo, vecs[i].cyc});
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      drain(vecs[i].name, oh, ol, 0);
    end

    // mult under flush: never accepted.
    oh = HI; ol = LO;
    sb.push_back('{oh, ol, 0});
    issue(3'd1, 32'hFFFFFFFE, 32'd3, 1'b1);
    drain("mult_req", oh, ol, 0);

    // Start (mthi) during RUN is ignored; req during RUN does not cancel.
    oh = HI; ol = LO;
    sb.push_back('{32'h0, 32'h0000002A, 5});
    issue(3'd1, 32'd6, 32'd7, 1'b0);
    chk("midrun busy c1", {31'b0, busy}, 32'd1);
    start = 1'b1; op = 3'd5; A = 32'hDEADBEEF;
    @(negedge clk);
    chk("midrun busy c2", {31'b0, busy}, 32'd1);
    start = 1'b0; op = 3'd0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    drain("midrun", oh, ol, 2);

    // Async reset in the 3rd busy cycle of a div.
    oh = HI; ol = LO;
    sb.push_back('{32'hCAFEF00D, ol, 0});
    issue(3'd5, 32'hCAFEF00D, 32'd0, 1'b0);
    drain("mthi_pre", oh, ol, 0);
    issue(3'd3, 32'd100, 32'd3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst busy c3", {31'b0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst HI", HI, 32'd0);
    chk("rst LO", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    sb.push_back('{32'h0, 32'hA5A5A5A5, 0});
    issue(3'd6, 32'hA5A5A5A5, 32'd0, 1'b0);
    drain("mtlo_post", 32'h0, 32'h0, 0);
    repeat (12) @(negedge clk);
    chk("post idle HI", HI, 32'h0);
    chk("post idle LO", LO, 32'hA5A5A5A5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/e_mdu_ctrl.md
Name: e_mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer in the Execute stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from E, owns HI/LO, and runs a cycle counter that emulates the real unit's latency.
- Drives `busy` so the D-stage stall logic can hold any later md-class instruction.
- Signed/unsigned operand interpretation follows the same sign/zero-extension rules used elsewhere in the datapath.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-low reset; all state clears immediately while low
- start  input  1  E-stage instruction is an md-class op this cycle
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 reserved, treated as none
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- req  input  1  exception/interrupt flush from M; suppresses acceptance this cycle
- busy  output  1  high while a mult/div is in flight
- HI  output  32  architectural HI
- LO  output  32  architectural LO

Behaviour:
- Reset (reset==0, async): state=IDLE, cnt=0, busy=0, HI=0, LO=0, temp_hi=0, temp_lo=0.
- States: IDLE, RUN.
- Accept condition: start & ~req & state==IDLE & op in 1..6, sampled at a rising edge. Anything else is ignored with no state change.
  - start while RUN: ignored; stall logic must prevent this, bench checks it is harmless.
  - start with req=1: ignored in any state.
- mthi/mtlo accepted: HI (or LO) <= A at that edge. busy stays 0; new value visible next cycle.
- mult/multu accepted at edge E0:
  - temp {hi,lo} <= 64-bit product. Signed for mult (both operands sign-extended to 64); unsigned for multu (zero-extended).
  - cnt <= MULT_CYCLES; state <= RUN.
- div/divu accepted at edge E0 with B!=0:
  - temp_lo <= quotient; temp_hi <= remainder.
  - div: signed, quotient truncates toward zero, remainder takes the sign of A.
  - div with A=0x80000000, B=0xFFFFFFFF: temp_lo=0x80000000, temp_hi=0.
  - divu: unsigned.
  - cnt <= DIV_CYCLES; state <= RUN.
- div/divu with B==0: still enters RUN for DIV_CYCLES. HI/LO are left unchanged at completion (commit suppressed by a latched flag).
- In RUN, each edge: cnt <= cnt-1. On the edge where cnt==1: HI/LO <= temp (unless suppressed), state <= IDLE, cnt <= 0.
- busy = (state==RUN), registered. It is high for exactly N cycles after E0, and the new HI/LO is visible in the same cycle busy falls.
- HI/LO hold their old values throughout RUN.
- req asserted during RUN does not cancel the operation; the instruction has already committed past E.
- Reset low mid-RUN aborts: HI/LO=0, busy=0 immediately (async).
- Latency: mult result readable at cycle E0+MULT_CYCLES (counting the cycle after E0 as +1). div result readable at E0+DIV_CYCLES.
- No combinational path from start/op to busy. The stall unit combines (start | busy) itself.

Test Plan:
- mult, A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
- div, A=-7 (0xFFFFFFF9), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu, A=7, B=0 after mthi 0x1234 / mtlo 0x5678 -> busy 10 cycles; then HI=0x1234, LO=0x5678 unchanged.
- start mult with req=1 -> busy stays 0, HI/LO unchanged. Separately, a second start mid-RUN is ignored and the first result commits on schedule.
- Drive reset low in the 3rd busy cycle of a div -> busy=0, HI=LO=0 immediately. After release, a new mtlo 0xA5A5A5A5 is accepted normally.
